// File: rtl/conv_engine_arbiter_if.sv
// Requester-side job/response channels and engine-side operand/result signals
// shared between conv_engine_arbiter and its clients.
interface conv_engine_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ-1:0][4:0][4:0][7:0]   req_window;   // s8 elements
  logic [NUM_REQ-1:0][4:0][4:0][7:0]   req_weights;  // s8 elements
  logic [NUM_REQ-1:0]                  resp_valid;
  logic [NUM_REQ-1:0]                  resp_ready;
  logic signed [31:0]                  resp_data;
  logic                                resp_err;
  logic                                eng_start;
  logic [4:0][4:0][7:0]                eng_inputs;
  logic [4:0][4:0][7:0]                eng_weights;
  logic                                eng_done;
  logic signed [31:0]                  eng_result;

  modport slave (
    input  req_valid, req_window, req_weights, resp_ready, eng_done, eng_result,
    output req_ready, resp_valid, resp_data, resp_err, eng_start, eng_inputs, eng_weights
  );

  modport master (
    output req_valid, req_window, req_weights, resp_ready, eng_done, eng_result,
    input  req_ready, resp_valid, resp_data, resp_err, eng_start, eng_inputs, eng_weights
  );
endinterface

// File: rtl/conv_engine_arbiter.sv
// Round-robin arbiter sharing one 5x5 convolution engine between NUM_REQ requesters,
// with operand capture, start/hold engine protocol, and a watchdog on eng_done.
module conv_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_engine_arbiter_if.slave   bus,
  output logic                   busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  gnt;
  logic [IDX_W-1:0]  sel;
  logic              sel_found;
  logic              accept;
  logic              timeout;
  logic [WD_W-1:0]   wdog;

  // Rotating priority search starting at rr_ptr.
  always_comb begin : rr_search
    int               j;
    logic [IDX_W-1:0] cand;
    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    j         = 0;
    cand      = '0;
    sel_found = 1'b0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  // Gated by rst so req_ready reads 0 for the whole reset window.
  assign accept  = (state == IDLE) && sel_found && !rst;
  assign timeout = (wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin : state_reg
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin : next_state_logic
    next_state = state;
    unique case (state)
      IDLE:    if (accept)                      next_state = BUSY;
      BUSY:    if (bus.eng_done || timeout)     next_state = RESP;
      RESP:    if (bus.resp_ready[gnt])         next_state = IDLE;
      default:                                  next_state = IDLE;
    endcase
  end

  always_comb begin : output_logic
    bus.req_ready = '0;
    if (accept) bus.req_ready[sel] = 1'b1;
    bus.eng_start = (state == BUSY);
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      // NOTE: operand registers are reset too, so the engine never sees stale data after reset.
      bus.eng_inputs  <= '0;
      bus.eng_weights <= '0;
      bus.resp_valid  <= '0;
      bus.resp_data   <= '0;
      bus.resp_err    <= 1'b0;
      gnt             <= '0;
      rr_ptr          <= '0;
      wdog            <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.eng_inputs  <= bus.req_window[sel];
            bus.eng_weights <= bus.req_weights[sel];
            gnt             <= sel;
            wdog            <= '0;
          end
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          // A done coinciding with the last watchdog cycle is still a normal result.
          if (bus.eng_done) begin
            bus.resp_data  <= bus.eng_result;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
          end else if (timeout) begin
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt;
          end
        end
        RESP: begin
          if (bus.resp_ready[gnt]) begin
            bus.resp_valid <= '0;
            bus.resp_err   <= 1'b0;
            if (gnt == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
            else                            rr_ptr <= gnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Directed bench for conv_engine_arbiter: table of arbitration/engine-latency vectors
// plus hand-written backpressure, reset-mid-job and operand-capture sequences.
module tb_conv_engine_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   eng_lat  = 0;
  int   eng_cnt;

  always #5 clk = ~clk;

  conv_engine_arbiter_if #(.NUM_REQ(N)) bus ();

  conv_engine_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic [N-1:0] valid;
    int           lat;     // engine model: done visible in BUSY cycle lat+2
    int           grant;
    int           data;
    logic         err;
    int           starts;  // expected number of eng_start cycles
  } vec_t;

  vec_t vecs [11];

  function automatic logic signed [31:0] dot5(input logic [4:0][4:0][7:0] a,
                                              input logic [4:0][4:0][7:0] b);
    logic signed [31:0] s;
    s = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        s = s + $signed(a[3'(r)][3'(c)]) * $signed(b[3'(r)][3'(c)]);
    return s;
  endfunction

  // Engine model: counts start cycles, then pulses done with the dot product.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.eng_done   <= 1'b0;
      bus.eng_result <= '0;
      eng_cnt        <= 0;
    end else if (bus.eng_start && !bus.eng_done) begin
      if (eng_cnt >= eng_lat) begin
        bus.eng_done   <= 1'b1;
        bus.eng_result <= dot5(bus.eng_inputs, bus.eng_weights);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end else begin
      bus.eng_done <= 1'b0;
      eng_cnt      <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input int i, input int wv, input int ww);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        bus.req_window[2'(i)][3'(r)][3'(c)]  = 8'(wv);
        bus.req_weights[2'(i)][3'(r)][3'(c)] = 8'(ww);
      end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
  endtask

  task automatic wait_resp(output int starts);
    int n;
    n = 0;
    starts = 0;
    while (bus.resp_valid == '0 && n < 40) begin
      starts += int'(bus.eng_start);
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Entered shortly after a negedge; leaves one cycle after the response handshake.
  task automatic run_job(input vec_t v, input string tag);
    logic [N-1:0] oh;
    int           starts;
    oh = 4'(1) << v.grant;
    bus.req_valid = v.valid;
    eng_lat       = v.lat;
    #1;
    wait_ready();
    check({tag, " grant"}, 32'(bus.req_ready), 32'(oh));
    @(negedge clk); #1;
    check({tag, " ready_drop_start"}, 32'({bus.req_ready, bus.eng_start}), 32'({4'b0, 1'b1}));
    wait_resp(starts);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'(oh));
    check({tag, " resp_data"}, bus.resp_data, 32'(v.data));
    check({tag, " err_start"}, 32'({bus.resp_err, bus.eng_start}), 32'({v.err, 1'b0}));
    check({tag, " start_cycles"}, 32'(starts), 32'(v.starts));
    bus.resp_ready = oh;
    @(negedge clk); #1;
    bus.resp_ready = '0;
    check({tag, " back_idle"}, 32'({busy, |bus.resp_valid, bus.resp_err}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end

  initial begin
    int starts;

    vecs[0]  = '{4'b1111, 0,   0, 50,    1'b0, 2};
    vecs[1]  = '{4'b1111, 1,   1, -75,   1'b0, 3};
    vecs[2]  = '{4'b1111, 3,   2, -500,  1'b0, 5};
    vecs[3]  = '{4'b1111, 0,   3, 1225,  1'b0, 2};
    vecs[4]  = '{4'b1111, 2,   0, 50,    1'b0, 4};
    vecs[5]  = '{4'b1001, 0,   3, 1225,  1'b0, 2};
    vecs[6]  = '{4'b0110, 1,   1, -75,   1'b0, 3};
    vecs[7]  = '{4'b0011, 0,   0, 50,    1'b0, 2};
    vecs[8]  = '{4'b0100, 100, 2, 0,     1'b1, 8};
    vecs[9]  = '{4'b1000, 6,   3, 1225,  1'b0, 8};
    vecs[10] = '{4'b0010, 5,   1, -75,   1'b0, 7};

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    set_req(0, 1, 2);
    set_req(1, 3, -1);
    set_req(2, 1, 2);
    set_req(3, 7, 7);
    #1;
    check("reset_ctrl", 32'({busy, bus.eng_start, bus.req_ready, bus.resp_valid, bus.resp_err}), 32'(0));
    check("reset_data", bus.resp_data, 32'(0));
    check("reset_operands", 32'({|bus.eng_inputs, |bus.eng_weights}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Single job on requester 2, window all 1, weights all 2.
    run_job('{4'b0100, 2, 2, 50, 1'b0, 4}, "single");
    bus.req_valid = '0;
    set_req(2, -4, 5);

    // Contention and rotation table from a fresh reset.
    do_reset();
    for (int i = 0; i < 11; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Backpressure on requester 1 with other requesters pending.
    bus.req_valid = 4'b0010;
    eng_lat       = 1;
    #1;
    wait_ready();
    check("bp grant", 32'(bus.req_ready), 32'(4'b0010));
    @(negedge clk); #1;
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 4'b1101;
    wait_resp(starts);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp hold%0d ctrl", c),
            32'({bus.resp_valid, bus.req_ready, bus.eng_start, busy}),
            32'({4'b0010, 4'b0000, 1'b0, 1'b1}));
      check($sformatf("bp hold%0d data", c), bus.resp_data, 32'(-75));
      @(negedge clk); #1;
    end
    bus.resp_ready = 4'b0010;
    @(negedge clk); #1;
    bus.resp_ready = '0;
    check("bp release", 32'({busy, bus.resp_valid, bus.req_ready}), 32'({1'b0, 4'b0000, 4'b0100}));
    bus.req_valid = '0;
    #1;
    check("drop before accept ready", 32'(bus.req_ready), 32'(0));
    @(negedge clk); #1;
    check("drop before accept idle", 32'(busy), 32'(0));

    // Asynchronous reset in the middle of a job.
    bus.req_valid = 4'b1000;
    eng_lat       = 3;
    #1;
    wait_ready();
    check("rst_mid grant", 32'(bus.req_ready), 32'(4'b1000));
    @(negedge clk); #1;
    check("rst_mid busy", 32'({busy, bus.eng_start, |bus.eng_inputs}), 32'(3'b111));
    rst           = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    check("rst_mid ctrl", 32'({busy, bus.eng_start, bus.req_ready, bus.resp_valid, bus.resp_err}), 32'(0));
    check("rst_mid data", bus.resp_data, 32'(0));
    check("rst_mid operands", 32'({|bus.eng_inputs, |bus.eng_weights}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid after release", 32'({bus.resp_valid, bus.req_ready}), 32'({4'b0000, 4'b0001}));
    run_job('{4'b1001, 0, 0, 50, 1'b0, 2}, "post_rst0");
    run_job('{4'b1001, 0, 3, 1225, 1'b0, 2}, "post_rst1");

    // Requester 0 changes its operands right after the accept.
    bus.req_valid = 4'b0001;
    eng_lat       = 2;
    #1;
    wait_ready();
    check("capture grant", 32'(bus.req_ready), 32'(4'b0001));
    @(negedge clk); #1;
    bus.req_valid = '0;
    set_req(0, 9, 9);
    #1;
    check("capture operand held", 32'(bus.eng_inputs[0][0]), 32'(1));
    wait_resp(starts);
    check("capture resp", 32'({bus.resp_valid, bus.resp_err}), 32'({4'b0001, 1'b0}));
    check("capture data", bus.resp_data, 32'(50));
    bus.resp_ready = 4'b0001;
    @(negedge clk); #1;
    bus.resp_ready = '0;
    check("capture idle", 32'(busy), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
